// File: rtl/clock_divider.sv
// clock_divider: registered integer clock divider. clk_div is high for
// DIVISOR/2 cycles then low for the rest of each DIVISOR-cycle period,
// with phase fixed relative to release of the synchronous reset.
module clock_divider #(
  parameter int DIVISOR = 2
) (
  input  logic clk,
  input  logic rst,
  output logic clk_div
);

  // Counter width is at least one bit, even for the smallest legal ratio.
  localparam int CW = ($clog2(DIVISOR) > 1) ? $clog2(DIVISOR) : 1;

  // Number of high cycles per period and the terminal count value.
  localparam logic [CW-1:0] HIGH_CNT = CW'(DIVISOR / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIVISOR - 1);

  // A ratio below two has no meaningful high/low phase; refuse to build.
  if (DIVISOR < 2) begin : g_bad_divisor
    $error("clock_divider: DIVISOR must be >= 2 (got %0d)", DIVISOR);
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_div_q, clk_div_d;

  // Next-state: output follows the current count; the counter wraps at
  // the terminal value, and any out-of-range value also returns to zero.
  always_comb begin
    cnt_d     = cnt_q;
    clk_div_d = 1'b0;
    clk_div_d = (cnt_q < HIGH_CNT);
    if (cnt_q >= LAST_CNT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset; reset wins over wrap/toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      clk_div_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_div_q <= clk_div_d;
    end
  end

  assign clk_div = clk_div_q;

endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: drives four dividers (ratios 2, 5, 4, 3) from one
// clock and reset, and compares every output after every edge against a
// reference that counts edges since the last reset.
module tb_clock_divider;

  localparam int N = 4;

  logic clk;
  logic rst;
  logic div2_out, div5_out, div4_out, div3_out;

  int errors = 0;
  int checks = 0;

  int divs[N] = '{2, 5, 4, 3};
  int k[N];           // non-reset edges seen since the last reset edge
  bit valid = 1'b0;   // outputs are defined only after a reset edge
  logic obs[N];

  clock_divider #(.DIVISOR(2)) u_div2 (.clk(clk), .rst(rst), .clk_div(div2_out));
  clock_divider #(.DIVISOR(5)) u_div5 (.clk(clk), .rst(rst), .clk_div(div5_out));
  clock_divider #(.DIVISOR(4)) u_div4 (.clk(clk), .rst(rst), .clk_div(div4_out));
  clock_divider #(.DIVISOR(3)) u_div3 (.clk(clk), .rst(rst), .clk_div(div3_out));

  // Clock: period 20.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Expected output: high during the first floor(D/2) edges of every
  // D-edge period counted from release, low otherwise and during reset.
  function automatic logic expected(input int edges, input int d);
    if (edges == 0) return 1'b0;
    return (((edges - 1) % d) < (d / 2)) ? 1'b1 : 1'b0;
  endfunction

  // Apply rst for one edge, then check every divider 1 time unit later.
  task automatic step(input logic r, input string tag);
    logic e;
    rst = r;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (r) k[i] = 0;
      else   k[i] = k[i] + 1;
    end
    if (r) valid = 1'b1;
    obs[0] = div2_out;
    obs[1] = div5_out;
    obs[2] = div4_out;
    obs[3] = div3_out;
    if (valid) begin
      for (int i = 0; i < N; i++) begin
        e = expected(k[i], divs[i]);
        checks++;
        assert (obs[i] === e) else begin
          errors++;
          $error("FAIL %s div%0d edge=%0d observed=%b expected=%b",
                 tag, divs[i], k[i], obs[i], e);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    foreach (k[i]) k[i] = 0;

    // Hold reset for 8 cycles: outputs go to 0 at the first edge and stay.
    repeat (8) step(1'b1, "reset_hold");

    // Release and run: 1,0,1,0 for ratio 2; 1,1,0,0,0 for ratio 5; etc.
    repeat (16) step(1'b0, "run_after_release");

    // Align ratio-2 output high, then reassert reset for 8 cycles.
    if (div2_out !== 1'b1) step(1'b0, "align_high");
    repeat (8) step(1'b1, "reset_mid_run");
    repeat (20) step(1'b0, "rerelease");

    // Ratio 4: reset exactly on the wrap edge (count 3), then resume.
    step(1'b1, "wrap_prep_reset");
    repeat (3) step(1'b0, "wrap_prep_run");
    step(1'b1, "reset_on_wrap");
    repeat (8) step(1'b0, "resume_after_wrap_reset");

    // A reset pulse between edges is never sampled and has no effect.
    @(negedge clk);
    rst = 1'b1;
    #3;
    rst = 1'b0;
    repeat (6) step(1'b0, "rst_glitch_ignored");

    // Randomized reset pulses and run lengths.
    for (int n = 0; n < 60; n++) begin
      int run_len;
      int rst_len;
      rst_len = $urandom_range(1, 3);
      run_len = $urandom_range(1, 25);
      repeat (rst_len) step(1'b1, "rand_reset");
      repeat (run_len) step(1'b0, "rand_run");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
